// File: rtl/instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// instr_fetch_reg
//
// Multicycle instruction fetch stage and instruction register (IR) of the MIPS
// datapath. A request from the control unit captures the fetch address, holds
// the memory read strobe for MEM_LAT cycles, and latches the returned word into
// the IR. The IR is presented as continuous field slices: opcode, rs, rt and
// the 16-bit immediate that feeds the sign-extension stage.
//
// Parameters
//   MEM_LAT      instruction memory read latency in cycles, legal range 1..15
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   fetch_start  in   fetch request, sampled only while idle
//   flush        in   synchronous abort/clear, wins over everything but reset
//   pc_in        in   [31:0] fetch address, captured with fetch_start
//   mem_addr     out  [31:0] word address to instruction memory (held when idle)
//   mem_rd       out  memory read strobe, high for the whole read
//   mem_data     in   [31:0] read data, sampled in the last read cycle
//   busy         out  high while a read is in flight (this is the FSM state:
//                     busy=1 <=> READ, busy=0 <=> IDLE)
//   fetch_done   out  one-cycle pulse after the IR has been loaded
//   ir_valid     out  level, IR holds a fetched instruction
//   opcode       out  [5:0]  IR[31:26]
//   rs           out  [4:0]  IR[25:21]
//   rt           out  [4:0]  IR[20:16]
//   imm16        out  [15:0] IR[15:0]
//   addr_err     out  one-cycle pulse on a misaligned request
//                     (only when FETCH_ALIGN_CHECK_EN is defined)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a request whose pc_in[1:0] is non-zero is rejected while idle:
//   no read is started, IR and ir_valid are untouched, and addr_err pulses.
//
// Handshake: fetch_start is a request with busy as its inverted ready. A
// request is accepted on a rising edge only when busy=0 and flush=0 (and, with
// the alignment check, pc_in is word aligned). Requests while busy=1 are
// dropped, not queued. Completion is signalled by the fetch_done pulse; a new
// request may be raised in that same cycle.
// -----------------------------------------------------------------------------
module instr_fetch_reg #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [31:0] pc_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic        fetch_done,
  output logic        ir_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // Counter is loaded with the number of read cycles still to go after the
  // first one, so the word is latched on the edge where it reads zero.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] ir_q;
  logic [31:0] addr_q;
  logic        done_q;
  logic        valid_q;
  logic        misaligned;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q;
`endif

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Abort: any in-flight read is forgotten, so its data is never latched.
      // mem_addr keeps its last value.
      state_q <= IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fetch_start) begin
            if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
              err_q <= 1'b1;
`endif
            end else begin
              addr_q  <= pc_in;
              cnt_q   <= LAT_M1;
              valid_q <= 1'b0;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (cnt_q == 4'd0) begin
            ir_q    <= mem_data;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd     = (state_q == READ);
  assign busy       = (state_q == READ);
  assign fetch_done = done_q;
  assign ir_valid   = valid_q;
  assign opcode     = ir_q[31:26];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign imm16      = ir_q[15:0];
`ifdef FETCH_ALIGN_CHECK_EN
  assign addr_err   = err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_reg.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_reg
//
// Two instances share all stimulus: u_lat1 (MEM_LAT=1) and u_lat3 (MEM_LAT=3).
// Each has its own instruction memory port reading a common fixed memory image.
// A directed vector table, hand-written corner sequences and a randomized run
// are all compared against constants and a fetch-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_fetch_reg;

  localparam logic [31:0] W0 = 32'h8C22_0010;
  localparam logic [31:0] W1 = 32'h2128_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = '0;

  logic [31:0] mem [64];

  logic [31:0] addr1, addr3, data1, data3;
  logic        rd1, rd3, busy1, busy3, done1, done3, valid1, valid3, err1, err3;
  logic [5:0]  op1, op3;
  logic [4:0]  rs1, rs3, rt1, rt3;
  logic [15:0] imm1, imm3;

  assign data1 = mem[addr1[7:2]];
  assign data3 = mem[addr3[7:2]];
`ifndef FETCH_ALIGN_CHECK_EN
  assign err1 = 1'b0;
  assign err3 = 1'b0;
`endif

  instr_fetch_reg #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .flush(flush),
    .pc_in(pc_in), .mem_addr(addr1), .mem_rd(rd1), .mem_data(data1),
    .busy(busy1), .fetch_done(done1), .ir_valid(valid1),
    .opcode(op1), .rs(rs1), .rt(rt1), .imm16(imm1)
`ifdef FETCH_ALIGN_CHECK_EN
    , .addr_err(err1)
`endif
  );

  instr_fetch_reg #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .flush(flush),
    .pc_in(pc_in), .mem_addr(addr3), .mem_rd(rd3), .mem_data(data3),
    .busy(busy3), .fetch_done(done3), .ir_valid(valid3),
    .opcode(op3), .rs(rs3), .rt(rt3), .imm16(imm3)
`ifdef FETCH_ALIGN_CHECK_EN
    , .addr_err(err3)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Per instance: cycles of read still outstanding, the word address being read,
  // the IR contents, and the two single-cycle pulses.
  int          lat_k [2] = '{1, 3};
  int          m_rem [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_ir [2];
  logic        m_valid [2];
  logic        m_done [2];
  logic        m_err [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_addr[k] = '0; m_ir[k] = '0;
      m_valid[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (flush) begin
        m_rem[k] = 0; m_ir[k] = '0; m_valid[k] = 1'b0;
      end else if (m_rem[k] > 0) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_ir[k] = mem[m_addr[k][7:2]];
          m_done[k] = 1'b1;
          m_valid[k] = 1'b1;
        end
      end else if (fetch_start) begin
        if (ALIGN_EN && pc_in[1:0] != 2'b00) begin
          m_err[k] = 1'b1;
        end else begin
          m_addr[k] = pc_in;
          m_rem[k] = lat_k[k];
          m_valid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input string tag,
                            input logic [31:0] a, input logic rd, input logic bz,
                            input logic dn, input logic v, input logic [31:0] ir,
                            input logic er);
    chk({tag, ".mem_addr"},   a,  m_addr[k]);
    chk({tag, ".mem_rd"},     32'(rd), 32'(m_rem[k] > 0));
    chk({tag, ".busy"},       32'(bz), 32'(m_rem[k] > 0));
    chk({tag, ".fetch_done"}, 32'(dn), 32'(m_done[k]));
    chk({tag, ".ir_valid"},   32'(v),  32'(m_valid[k]));
    chk({tag, ".ir"},         ir, m_ir[k]);
    chk({tag, ".addr_err"},   32'(er), 32'(m_err[k]));
  endtask

  task automatic check_model();
    check_inst(0, "model.lat1", addr1, rd1, busy1, done1, valid1,
               {op1, rs1, rt1, imm1}, err1);
    check_inst(1, "model.lat3", addr3, rd3, busy3, done3, valid3,
               {op3, rs3, rt3, imm3}, err3);
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input logic fs, input logic fl, input logic [31:0] pc);
    fetch_start = fs;
    flush = fl;
    pc_in = pc;
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic        fs;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] a1;
    logic        rd1;
    logic        dn1;
    logic        v1;
    logic [31:0] ir1;
    logic [31:0] a3;
    logic        rd3;
    logic        dn3;
    logic        v3;
    logic [31:0] ir3;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // memory image: fixed for the whole run
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = W0;
    mem[1] = W1;

    // Inputs for one cycle, then expected outputs after the following edge.
    //            fs    fl    pc      | a1     rd1   dn1   v1    ir1   | a3     rd3   dn3   v3    ir3
    tbl[0]  = '{1'b1, 1'b0, 32'h4, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b1, W1,    32'h4, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, W1,    32'h4, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, W0,    32'h4, 1'b0, 1'b1, 1'b1, W1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, W0,    32'h0, 1'b1, 1'b0, 1'b0, W1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, W0,    32'h0, 1'b1, 1'b0, 1'b0, W1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, W0,    32'h0, 1'b1, 1'b0, 1'b0, W1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, W0,    32'h0, 1'b0, 1'b1, 1'b1, W0};
    tbl[8]  = '{1'b1, 1'b0, 32'h4, 32'h4, 1'b1, 1'b0, 1'b0, W0,    32'h4, 1'b1, 1'b0, 1'b0, W0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b1, W1,    32'h4, 1'b1, 1'b0, 1'b0, W0};
    tbl[10] = '{1'b0, 1'b1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 32'h8, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0};

    // ------------------------------------------------ reset
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset.lat1.mem_rd", 32'(rd1), 32'h0);
    chk("reset.lat1.busy", 32'(busy1), 32'h0);
    chk("reset.lat1.fetch_done", 32'(done1), 32'h0);
    chk("reset.lat1.ir_valid", 32'(valid1), 32'h0);
    chk("reset.lat1.ir", {op1, rs1, rt1, imm1}, 32'h0);
    chk("reset.lat1.mem_addr", addr1, 32'h0);
    chk("reset.lat1.addr_err", 32'(err1), 32'h0);
    chk("reset.lat3.mem_rd", 32'(rd3), 32'h0);
    chk("reset.lat3.ir", {op3, rs3, rt3, imm3}, 32'h0);
    chk("reset.lat3.ir_valid", 32'(valid3), 32'h0);

    // ------------------------------------------------ directed vectors
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].fs, tbl[i].fl, tbl[i].pc);
      tick();
      chk($sformatf("vec%0d.lat1.mem_addr", i), addr1, tbl[i].a1);
      chk($sformatf("vec%0d.lat1.mem_rd", i), 32'(rd1), 32'(tbl[i].rd1));
      chk($sformatf("vec%0d.lat1.busy", i), 32'(busy1), 32'(tbl[i].rd1));
      chk($sformatf("vec%0d.lat1.fetch_done", i), 32'(done1), 32'(tbl[i].dn1));
      chk($sformatf("vec%0d.lat1.ir_valid", i), 32'(valid1), 32'(tbl[i].v1));
      chk($sformatf("vec%0d.lat1.ir", i), {op1, rs1, rt1, imm1}, tbl[i].ir1);
      chk($sformatf("vec%0d.lat3.mem_addr", i), addr3, tbl[i].a3);
      chk($sformatf("vec%0d.lat3.mem_rd", i), 32'(rd3), 32'(tbl[i].rd3));
      chk($sformatf("vec%0d.lat3.busy", i), 32'(busy3), 32'(tbl[i].rd3));
      chk($sformatf("vec%0d.lat3.fetch_done", i), 32'(done3), 32'(tbl[i].dn3));
      chk($sformatf("vec%0d.lat3.ir_valid", i), 32'(valid3), 32'(tbl[i].v3));
      chk($sformatf("vec%0d.lat3.ir", i), {op3, rs3, rt3, imm3}, tbl[i].ir3);
      if (i == 1) begin
        // decoded fields of 0x2128FFFC after a MEM_LAT=1 fetch
        chk("vec1.lat1.opcode", 32'(op1), 32'h08);
        chk("vec1.lat1.rs", 32'(rs1), 32'd9);
        chk("vec1.lat1.rt", 32'(rt1), 32'd8);
        chk("vec1.lat1.imm16", 32'(imm1), 32'hFFFC);
      end
    end
    drive(1'b0, 1'b0, 32'h0);

    // ------------------------------------------------ async reset mid-READ
    drive(1'b1, 1'b0, 32'h8);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.lat1.mem_rd", 32'(rd1), 32'h0);
    chk("areset.lat3.mem_rd", 32'(rd3), 32'h0);
    chk("areset.lat3.busy", 32'(busy3), 32'h0);
    chk("areset.lat3.ir_valid", 32'(valid3), 32'h0);
    chk("areset.lat3.ir", {op3, rs3, rt3, imm3}, 32'h0);
    chk("areset.lat3.mem_addr", addr3, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

`ifdef FETCH_ALIGN_CHECK_EN
    // ------------------------------------------------ misaligned request
    drive(1'b1, 1'b0, 32'h4);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    drive(1'b1, 1'b0, 32'h6);
    tick();
    chk("align.lat1.addr_err", 32'(err1), 32'h1);
    chk("align.lat3.addr_err", 32'(err3), 32'h1);
    chk("align.lat1.mem_rd", 32'(rd1), 32'h0);
    chk("align.lat3.mem_rd", 32'(rd3), 32'h0);
    chk("align.lat3.ir", {op3, rs3, rt3, imm3}, W1);
    chk("align.lat3.ir_valid", 32'(valid3), 32'h1);
    chk("align.lat3.mem_addr", addr3, 32'h4);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("align.lat3.addr_err_pulse", 32'(err3), 32'h0);
    chk("align.lat3.mem_rd_after", 32'(rd3), 32'h0);
    // flush wins over a misaligned request
    drive(1'b1, 1'b1, 32'h6);
    tick();
    chk("align.flush.lat3.addr_err", 32'(err3), 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
`endif

    // ------------------------------------------------ randomized run
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), pc);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
